uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL provide parameter HEADER, default 8'hA5, frame header byte.
REQ-002 SHALL provide parameter GAP, default 2, idle clk cycles inserted between frames (0..255).
REQ-003 clk  input  1  system clock (12 MHz).
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1 each  requester frame request, level, held until ack.
REQ-006 data0 / data1  input  32 each  requester payload, stable while req high.
REQ-007 ack0 / ack1  output  1 each  one-cycle pulse, frame fully transmitted.
REQ-008 tx_data_valid  output  1  one-cycle byte strobe to UART transmitter.
REQ-009 tx_data_in  output  8  byte to transmit, valid with strobe.
REQ-010 tx_busy  input  1  UART transmitter busy (its bit-clock enable).
REQ-011 busy  output  1  high from grant until ack cycle inclusive.

Function
REQ-012 Frame SHALL be 7 bytes in order: HEADER, ID (8'h00 for req0, 8'h01 for req1), payload[31:24], [23:16], [15:8], [7:0], CHK.
REQ-013 CHK SHALL be the 8-bit modulo-256 sum of ID and the four payload bytes; carries discarded.
REQ-014 Payload SHALL be latched into an internal register at grant; later data changes are ignored.
REQ-015 Arbitration SHALL be round-robin: priority pointer starts at ch0 after reset and moves to the other channel after each grant.
REQ-016 Grant with only one request SHALL go to that channel regardless of pointer.
REQ-017 FSM states: IDLE, SEND, WAIT_HI, WAIT_LO, NEXT, DONE, GAP.
REQ-018 IDLE: if any req, grant, latch payload/ID, clear byte index, go to SEND next cycle.
REQ-019 SEND: only if tx_busy low, assert tx_data_valid for exactly one cycle with tx_data_in = byte[index]; go to WAIT_HI; else remain in SEND.
REQ-020 WAIT_HI: wait for tx_busy high; if not seen within 8 cycles, return to SEND and re-issue the same byte.
REQ-021 WAIT_LO: wait for tx_busy low, then NEXT.
REQ-022 NEXT: index 6 -> DONE; else index+1 -> SEND.
REQ-023 DONE: pulse ack of granted channel for one cycle, advance pointer, go to GAP.
REQ-024 GAP: count GAP cycles then IDLE; GAP=0 goes directly to IDLE.
REQ-025 tx_data_in SHALL hold its last value when strobe is low.
REQ-026 A requester dropping req mid-frame SHALL NOT abort the frame; ack still pulses.
REQ-027 req sampled in DONE/GAP SHALL NOT be granted until IDLE.
REQ-028 Byte-to-byte latency: next strobe no earlier than 2 cycles after tx_busy falls.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE, tx_data_valid 0, tx_data_in 8'h00, ack0/ack1 0, busy 0, pointer ch0, index 0, payload 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no ack; first frame after release restarts at HEADER.

Verification
REQ-031 req0, data0=32'h11223344, UART model -> bytes A5,00,11,22,33,44,AA; one ack0 pulse; ack1 never.
REQ-032 req0 and req1 asserted same cycle after reset -> ch0 frame, GAP idle cycles, ch1 frame (ID 01); third simultaneous request -> ch0.
REQ-033 data1=32'hFFFFFFFF -> CHK 8'hFD (wrap-around).
REQ-034 UART model ignores first strobe of byte 3 -> after 8 cycles same byte re-strobed; frame content unchanged.
REQ-035 rst_n pulsed low during byte 4 -> outputs at reset values immediately; no ack; next frame starts with A5.
REQ-036 Check every strobe is one cycle, never while tx_busy high, and data0 change after grant not transmitted.

Source files
------------

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Two-requester frame scheduler in front of a byte-wide UART transmitter.
// A granted requester's 32-bit payload is sent as a 7-byte frame:
//   HEADER, ID (0x00 / 0x01), payload[31:24..7:0], CHK
// CHK is the modulo-256 sum of ID and the four payload bytes.
// Requesters are served round-robin; after each frame GAP idle cycles are
// inserted before the next grant.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   req0/req1      frame request (level, held until ack)
//   data0/data1    payload, sampled once at grant
//   ack0/ack1      one-cycle pulse when the granted frame is fully sent
//   tx_data_valid  one-cycle byte strobe to the UART transmitter
//   tx_data_in     byte for the UART, held between strobes
//   tx_busy        UART transmitter busy
//   busy           high from grant through the ack cycle
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned GAP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        tx_data_valid,
    output logic [7:0]  tx_data_in,
    input  logic        tx_busy,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_WAIT_HI, ST_WAIT_LO, ST_NEXT, ST_DONE, ST_GAP
    } state_t;

    // WAIT_HI gives up after 8 cycles without tx_busy and re-issues the byte.
    localparam logic [7:0] WAIT_LAST = 8'd7;
    localparam logic [7:0] GAP_LAST  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);
    localparam logic [2:0] LAST_IDX  = 3'd6;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_payload;
    logic        r_gnt;      // channel currently being served
    logic        r_ptr;      // channel that wins a simultaneous request
    logic [2:0]  r_idx;
    logic [7:0]  r_cnt;      // shared by the WAIT_HI timeout and the GAP count
    logic        r_txv;
    logic [7:0]  r_txd;

    logic        w_gnt_ch;
    logic        w_grant;
    logic        w_strobe;
    logic        w_idx_inc;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_ptr_adv;
    logic [7:0]  w_byte;

    function automatic logic [7:0] checksum8(input logic [7:0] id, input logic [31:0] p);
        // 8-bit result width discards the carries.
        return id + p[31:24] + p[23:16] + p[15:8] + p[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic gnt,
                                              input logic [31:0] p);
        logic [7:0] b;
        logic [7:0] id;
        id = {7'd0, gnt};
        b  = HEADER;
        case (idx)
            3'd0:    b = HEADER;
            3'd1:    b = id;
            3'd2:    b = p[31:24];
            3'd3:    b = p[23:16];
            3'd4:    b = p[15:8];
            3'd5:    b = p[7:0];
            3'd6:    b = checksum8(id, p);
            default: b = HEADER;
        endcase
        return b;
    endfunction

    // A lone request wins regardless of the pointer.
    assign w_gnt_ch = (req0 && req1) ? r_ptr : req1;
    assign w_byte   = frame_byte(r_idx, r_gnt, r_payload);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_strobe    = 1'b0;
        w_idx_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_ptr_adv   = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        busy        = (r_state != ST_IDLE) && (r_state != ST_GAP);
        unique case (r_state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    w_strobe    = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_LO;
                end else if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                ack0        = !r_gnt;
                ack1        = r_gnt;
                w_ptr_adv   = 1'b1;
                w_cnt_clr   = 1'b1;
                w_state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= 32'd0;
            r_gnt     <= 1'b0;
            r_ptr     <= 1'b0;
            r_idx     <= 3'd0;
            r_cnt     <= 8'd0;
            r_txv     <= 1'b0;
            r_txd     <= 8'h00;
        end else begin
            r_txv <= w_strobe;
            if (w_grant) begin
                r_gnt     <= w_gnt_ch;
                r_payload <= w_gnt_ch ? data1 : data0;
                r_idx     <= 3'd0;
            end
            if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_cnt_clr) begin
                r_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_strobe) begin
                r_txd <= w_byte;
            end
            if (w_ptr_adv) begin
                r_ptr <= !r_gnt;
            end
        end
    end

    assign tx_data_valid = r_txv;
    assign tx_data_in    = r_txd;

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam logic [7:0] HDR   = 8'hA5;
    localparam int         GAPC  = 2;
    localparam int         LIMIT = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        ack0, ack1;
    logic        tx_data_valid;
    logic [7:0]  tx_data_in;
    logic        tx_busy;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_sched #(.HEADER(HDR), .GAP(GAPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0          (req0),
        .req1          (req1),
        .data0         (data0),
        .data1         (data1),
        .ack0          (ack0),
        .ack1          (ack1),
        .tx_data_valid (tx_data_valid),
        .tx_data_in    (tx_data_in),
        .tx_busy       (tx_busy),
        .busy          (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit mptr;

    function automatic logic [7:0] exp_byte(input bit ch, input logic [31:0] d, input int i);
        int sum;
        sum = int'(ch);
        for (int k = 0; k < 4; k++) sum = sum + int'((d >> (8 * k)) & 32'hFF);
        case (i)
            0:          return HDR;
            1:          return 8'(ch);
            2, 3, 4, 5: return 8'((d >> (8 * (5 - i))) & 32'hFF);
            default:    return 8'(sum % 256);
        endcase
    endfunction

    function automatic bit pick(input bit r0, input bit r1, input bit p);
        if (r0 && r1) return p;
        return r1;
    endfunction

    // ---------------- UART transmitter model ----------------
    logic [7:0] cap[$];
    bit         ign_arm  = 0;
    bit         ign_hit  = 0;
    int         ign_cyc  = -1;
    logic [7:0] ign_byte = 8'h00;
    int         cyc      = 0;
    int         fall_cyc = -100;

    initial begin
        bit pend;
        bit prev_v;
        int dly;
        int hold;
        pend   = 0;
        prev_v = 0;
        dly    = 0;
        hold   = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                tx_busy = 1'b0;
                pend    = 0;
                prev_v  = 0;
                ign_cyc = -1;
                continue;
            end
            if (tx_data_valid) begin
                check("strobe_while_busy", tx_busy, 1'b0);
                check("strobe_one_cycle", prev_v, 1'b0);
                check("strobe_latency", (cyc - fall_cyc) >= 2, 1'b1);
                if (ign_arm && cap.size() == 3) begin
                    ign_arm  = 0;
                    ign_cyc  = cyc;
                    ign_byte = tx_data_in;
                end else begin
                    if (ign_cyc >= 0) begin
                        check("retry_delay", ((cyc - ign_cyc) >= 9) && ((cyc - ign_cyc) <= 10), 1'b1);
                        check("retry_byte", tx_data_in, ign_byte);
                        ign_cyc = -1;
                        ign_hit = 1;
                    end
                    cap.push_back(tx_data_in);
                    pend = 1;
                    dly  = $urandom_range(0, 3);
                    hold = $urandom_range(1, 6);
                end
            end
            prev_v = tx_data_valid;
            if (pend) begin
                if (dly == 0) begin
                    tx_busy = 1'b1;
                    pend    = 0;
                end else begin
                    dly--;
                end
            end else if (tx_busy) begin
                if (hold <= 1) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                end else begin
                    hold--;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_busy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < LIMIT);
        check("grant_timeout", busy, 1'b1);
    endtask

    task automatic wait_ack(input bit ch, input logic [31:0] d, output bit ok);
        int n;
        n  = 0;
        ok = 1;
        while (!(ack0 || ack1) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!(ack0 || ack1)) begin
            check("ack_timeout", 1'b0, 1'b1);
            ok = 0;
            return;
        end
        check("ack_channel", ack1, ch);
        check("ack_both", ack0 && ack1, 1'b0);
        check("busy_at_ack", busy, 1'b1);
        check("frame_len", cap.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < cap.size()) check($sformatf("byte%0d", i), cap[i], exp_byte(ch, d, i));
        end
        cap.delete();
        if (ch) req1 = 1'b0;
        else    req0 = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", ack0 || ack1, 1'b0);
        check("busy_after_ack", busy, 1'b0);
    endtask

    task automatic do_round(input bit r0, input bit r1, input logic [31:0] d0,
                            input logic [31:0] d1, input bit mutate, input bit drop,
                            input bit check_gap);
        bit          p0, p1, ch, ok, first;
        logic [31:0] dch;
        int          n;
        p0 = r0;
        p1 = r1;
        first = 1;
        @(negedge clk);
        data0 = d0;
        data1 = d1;
        req0  = r0;
        req1  = r1;
        while (p0 || p1) begin
            ch  = pick(p0, p1, mptr);
            dch = ch ? d1 : d0;
            wait_busy(n);
            // busy stays low for the GAP cycles plus the IDLE cycle that grants.
            if (!first && check_gap) check("gap_cycles", n, GAPC + 1);
            if (mutate) begin
                if (ch) data1 = d1 ^ ($urandom | 32'h1);
                else    data0 = d0 ^ ($urandom | 32'h1);
            end
            if (drop) begin
                if (ch) req1 = 1'b0;
                else    req0 = 1'b0;
            end
            wait_ack(ch, dch, ok);
            if (!ok) begin
                req0 = 1'b0;
                req1 = 1'b0;
                break;
            end
            if (ch) p1 = 0;
            else    p0 = 0;
            mptr  = !ch;
            first = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit ok;
        rst_n = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 32'd0;
        data1 = 32'd0;
        mptr  = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", tx_data_valid, 1'b0);
        check("rst_data", tx_data_in, 8'h00);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Simultaneous requests after reset: ch0, gap, ch1; then again ch0 first.
        do_round(1, 1, $urandom, $urandom, 0, 0, 1);
        do_round(1, 1, $urandom, $urandom, 0, 0, 1);

        // Known frame A5 00 11 22 33 44 AA.
        do_round(1, 0, 32'h11223344, 32'd0, 0, 0, 0);

        // Checksum wrap-around: 01 + 4*FF -> FD.
        do_round(0, 1, 32'd0, 32'hFFFFFFFF, 0, 0, 0);

        // UART swallows the first strobe of byte 3.
        ign_hit = 0;
        ign_arm = 1;
        do_round(1, 0, $urandom, 32'd0, 0, 0, 0);
        check("retry_seen", ign_hit, 1'b1);
        ign_arm = 0;

        // Reset in the middle of byte 4.
        @(negedge clk);
        data0 = 32'hDEADBEEF;
        req0  = 1'b1;
        n = 0;
        while (cap.size() < 5 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte4", cap.size() >= 5, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", tx_data_valid, 1'b0);
        check("mid_rst_data", tx_data_in, 8'h00);
        check("mid_rst_ack", ack0 || ack1, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_ack", ack0 || ack1, 1'b0);
        end
        cap.delete();
        mptr  = 0;
        rst_n = 1'b1;
        wait_busy(n);
        wait_ack(0, 32'hDEADBEEF, ok);

        // Randomized rounds with data changes after grant and early req drops.
        for (int r = 0; r < 12; r++) begin
            logic [1:0]  pat;
            logic [31:0] a, b;
            pat = 2'($urandom_range(1, 3));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) ign_arm = 1;
            do_round(pat[0], pat[1], a, b, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1);
            ign_arm = 0;
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
